// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 serializer:
//   - state_t        : frame-level FSM encoding (IDLE, SEND, LATCH)
//   - DEF_*          : default timing constants for a 12 MHz clock
//   - gamma8()       : square-law gamma curve, g(x) = (x*x + 255) >> 8
// ---------------------------------------------------------------------------
package ws2812_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    localparam int DEF_LEDS         = 32;
    localparam int DEF_BIT_CYCLES   = 12;
    localparam int DEF_T0H_CYCLES   = 4;
    localparam int DEF_T1H_CYCLES   = 8;
    localparam int DEF_RESET_CYCLES = 600;

    // The +255 bias makes g(255) land exactly on 255 while g(0) stays 0.
    // 255*255 + 255 = 65280 fits the 16-bit intermediate without overflow.
    function automatic logic [7:0] gamma8(input logic [7:0] x);
        logic [15:0] sq;
        sq = ({8'd0, x} * {8'd0, x}) + 16'd255;
        return sq[15:8];
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ---------------------------------------------------------------------------
// ws2812_bit_encoder
// Generates the pulse-width waveform for one WS2812 bit period at a time.
// The phase counter runs 0..BIT_CYCLES-1 while run=1 and is held at 0
// otherwise, so every new run starts on a fresh bit boundary.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   bit_val    in   value of the bit currently being sent
//   run        in   high while the serializer is in SEND
//   dout_next  out  line level for the current phase (registered by top)
//   bit_done   out  last phase of the current bit period
//   bit_start  out  first phase of the current bit period
// ---------------------------------------------------------------------------
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_val,
    input  logic run,
    output logic dout_next,
    output logic bit_done,
    output logic bit_start
);

    localparam int PW = $clog2(BIT_CYCLES);
    localparam logic [PW-1:0] LAST_PHASE = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0] T0H        = PW'(T0H_CYCLES);
    localparam logic [PW-1:0] T1H        = PW'(T1H_CYCLES);

    logic [PW-1:0] phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (!run || phase == LAST_PHASE) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign dout_next = run && (phase < (bit_val ? T1H : T0H));
    assign bit_done  = run && (phase == LAST_PHASE);
    assign bit_start = run && (phase == '0);

endmodule

// File: rtl/ws2812_serializer.sv
// ---------------------------------------------------------------------------
// ws2812_serializer
// Pulls colour bytes from an upstream source and shifts them MSB-first onto
// a WS2812 one-wire line. A frame is LEDS*3 bytes followed by a low latch of
// RESET_CYCLES cycles. Frames start only while trigger is high in IDLE.
// Optional feature macro: WS2812_GAMMA_EN -- when defined every captured
// byte passes through the gamma8() curve before being stored.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   trigger       in   source has a frame ready (level)
//   color_now     in   current colour byte from the source
//   data_request  out  one-cycle pulse: byte consumed, source advances
//   dout          out  WS2812 serial data (registered)
//   busy          out  high whenever a frame or latch is in progress
// ---------------------------------------------------------------------------
module ws2812_serializer
    import ws2812_pkg::*;
#(
    parameter int LEDS         = DEF_LEDS,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic [7:0] color_now,
    output logic       data_request,
    output logic       dout,
    output logic       busy
);

    localparam int BYTES = LEDS * 3;
    localparam int BW    = $clog2(BYTES);
    localparam int LW    = $clog2(RESET_CYCLES);
    localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES - 1);
    localparam logic [LW-1:0] LAST_LATCH = LW'(RESET_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      shift;
    logic [7:0]      next_byte;
    logic [7:0]      captured;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   byte_cnt;
    logic [LW-1:0]   latch_cnt;
    logic            dout_next;
    logic            bit_done;
    logic            bit_start;
    logic            more_bytes;

`ifdef WS2812_GAMMA_EN
    assign captured = gamma8(color_now);
`else
    assign captured = color_now;
`endif

    assign more_bytes = (byte_cnt < LAST_BYTE);
    assign busy       = (state != S_IDLE);

    ws2812_bit_encoder #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_bit_encoder (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_val   (shift[bit_idx]),
        .run       (state == S_SEND),
        .dout_next (dout_next),
        .bit_done  (bit_done),
        .bit_start (bit_start)
    );

    // Next-state and handshake. The request is gated by rst_n so the source
    // never advances while the serializer is held in reset.
    always_comb begin
        state_nxt    = state;
        data_request = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger && rst_n) begin
                    data_request = 1'b1;
                    state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                // Prefetch the following byte at the start of the last bit,
                // so it is ready when this byte's final period ends.
                if (bit_start && bit_idx == 3'd0 && more_bytes) begin
                    data_request = 1'b1;
                end
                if (bit_done && bit_idx == 3'd0 && !more_bytes) begin
                    state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                if (latch_cnt == LAST_LATCH) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            dout  <= 1'b0;
        end else begin
            state <= state_nxt;
            dout  <= dout_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift     <= '0;
            next_byte <= '0;
            bit_idx   <= '0;
            byte_cnt  <= '0;
            latch_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (data_request) begin
                        shift    <= captured;
                        byte_cnt <= '0;
                        bit_idx  <= 3'd7;
                    end
                end
                S_SEND: begin
                    if (data_request) begin
                        next_byte <= captured;
                    end
                    if (bit_done) begin
                        if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                        end else if (more_bytes) begin
                            shift    <= next_byte;
                            byte_cnt <= byte_cnt + 1'b1;
                            bit_idx  <= 3'd7;
                        end else begin
                            latch_cnt <= '0;
                        end
                    end
                end
                S_LATCH: begin
                    if (latch_cnt == LAST_LATCH) begin
                        latch_cnt <= '0;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_serializer.sv
// ---------------------------------------------------------------------------
// tb_ws2812_serializer
// Directed bench for ws2812_serializer with LEDS=2 (6 bytes, 48 bits/frame).
// The line is decoded from dout high times; expected bytes are hand-set.
// ---------------------------------------------------------------------------
module tb_ws2812_serializer;

    localparam int LEDS  = 2;
    localparam int BITC  = 12;
    localparam int NBYTE = LEDS * 3;
    localparam int NBITS = NBYTE * 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trigger = 1'b0;
    logic [7:0] color_now;
    logic       data_request;
    logic       dout;
    logic       busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         req_cnt = 0;
    int         last_rise = -1;
    int         first_rise = -1;
    int         busy_run = 0;
    int         last_busy_len = 0;
    logic       prev_dout = 1'b0;
    logic       prev_busy = 1'b0;
    logic       s_dout, s_busy, s_req;
    int         hl_q[$];
    logic [7:0] exp_bytes[NBYTE];
    int         src_mode = 0;
    int         src_idx = 0;

    always #5 clk = ~clk;

    ws2812_serializer #(.LEDS(LEDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trigger      (trigger),
        .color_now    (color_now),
        .data_request (data_request),
        .dout         (dout),
        .busy         (busy)
    );

    // Source model: constant, incrementing, or a short table.
    always_comb begin
        color_now = 8'h00;
        case (src_mode)
            0: color_now = 8'hA5;
            1: color_now = src_idx[7:0];
            2: color_now = (src_idx == 0) ? 8'h80 : (src_idx == 1) ? 8'hFF : 8'h00;
            default: color_now = 8'h00;
        endcase
    end

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock: sample at the falling edge, then return just after the
    // rising edge, where the bench changes inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_dout = dout;
        s_busy = busy;
        s_req  = data_request;
        if (s_dout && !prev_dout) begin
            if (last_rise >= 0 && (cyc - last_rise) < 100)
                check("bit_period", cyc - last_rise, BITC);
            if (first_rise < 0) first_rise = cyc;
            last_rise = cyc;
        end
        if (!s_dout && prev_dout && last_rise >= 0) hl_q.push_back(cyc - last_rise);
        if (s_req) req_cnt++;
        if (s_busy) busy_run++;
        else if (prev_busy) begin
            last_busy_len = busy_run;
            busy_run = 0;
        end
        prev_dout = s_dout;
        prev_busy = s_busy;
        @(posedge clk);
        #1;
        if (s_req) src_idx++;
    endtask

    task automatic clear_mon();
        hl_q.delete();
        last_rise  = -1;
        first_rise = -1;
        req_cnt    = 0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (!s_busy && n < 20) begin tick(); n++; end
        check("frame_started", s_busy, 1);
        n = 0;
        while (s_busy && n < 3000) begin tick(); n++; end
        check("frame_ended", s_busy, 0);
    endtask

    task automatic verify_frame(input string name);
        logic [7:0] got;
        int h;
        check({name, "_bits"}, hl_q.size(), NBITS);
        for (int i = 0; i < NBYTE; i++) begin
            got = 8'h00;
            for (int b = 0; b < 8; b++) begin
                h = (i * 8 + b < hl_q.size()) ? hl_q[i * 8 + b] : 0;
                check($sformatf("%s_hi_b%0d_%0d", name, i, b), h, exp_bytes[i][7 - b] ? 8 : 4);
                got = {got[6:0], (h == 8)};
            end
            check($sformatf("%s_byte%0d", name, i), got, exp_bytes[i]);
        end
    endtask

    initial begin
        // Reset state
        tick();
        check("rst_dout", s_dout, 0);
        check("rst_busy", s_busy, 0);
        check("rst_req", s_req, 0);
        rst_n = 1'b1;
        tick();
        check("idle_no_req", s_req, 0);

        // 1: constant 0xA5, single trigger pulse
        src_mode = 0;
        clear_mon();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        wait_frame();
        for (int i = 0; i < NBYTE; i++) exp_bytes[i] = 8'hA5;
        verify_frame("t1");
        check("t1_requests", req_cnt, NBYTE);
        check("t1_busy_len", last_busy_len, NBITS * BITC + 600);

        // 2: incrementing bytes, no gap, 576 cycles of bit periods
        src_mode = 1;
        src_idx  = 0;
        clear_mon();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        wait_frame();
        for (int i = 0; i < NBYTE; i++) exp_bytes[i] = 8'(i);
        verify_frame("t2");
        check("t2_requests", req_cnt, NBYTE);
        check("t2_rise_to_latch", last_rise + BITC - first_rise, NBITS * BITC);

        // 3: trigger held high across the latch
        src_mode = 0;
        clear_mon();
        trigger = 1'b1;
        wait_frame();
        check("t3_req_on_idle", s_req, 1);
        check("t3_latch_len", last_busy_len - NBITS * BITC, 600);
        trigger = 1'b0;
        clear_mon();
        wait_frame();
        for (int i = 0; i < NBYTE; i++) exp_bytes[i] = 8'hA5;
        verify_frame("t3b");

        // 4: reset mid-bit while dout is high
        src_mode = 1;
        src_idx  = 0;
        clear_mon();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (30) tick();
        for (int n = 0; n < 20 && dout !== 1'b1; n++) tick();
        check("t4_dout_high_before_rst", dout, 1);
        trigger = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t4_rst_dout", dout, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_req", data_request, 0);
        tick();
        tick();
        clear_mon();
        src_idx = 0;
        rst_n = 1'b1;
        tick();
        trigger = 1'b0;
        wait_frame();
        for (int i = 0; i < NBYTE; i++) exp_bytes[i] = 8'(i);
        verify_frame("t4");
        check("t4_requests", req_cnt, NBYTE);

        // 5: trigger dropped 100 cycles into the frame
        src_mode = 0;
        clear_mon();
        trigger = 1'b1;
        tick();
        repeat (100) tick();
        trigger = 1'b0;
        wait_frame();
        for (int i = 0; i < NBYTE; i++) exp_bytes[i] = 8'hA5;
        verify_frame("t5");
        check("t5_requests", req_cnt, NBYTE);
        repeat (50) tick();
        check("t5_stays_idle", s_busy, 0);
        check("t5_no_new_req", req_cnt, NBYTE);

        // 6: gamma path (0x80 -> 0x40 when enabled), 0xFF unchanged
        src_mode = 2;
        src_idx  = 0;
        clear_mon();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        wait_frame();
        for (int i = 0; i < NBYTE; i++) exp_bytes[i] = 8'h00;
`ifdef WS2812_GAMMA_EN
        exp_bytes[0] = 8'h40;
`else
        exp_bytes[0] = 8'h80;
`endif
        exp_bytes[1] = 8'hFF;
        verify_frame("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
